fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Parametrised instruction-fetch stage with a prefetch queue, decoupling instruction-cache latency from decode. Sits between the PC-redirect sources (WB branch/jump, trap/MTVEC) and the decode stage. It issues sequential fetch requests up to a credit limit, buffers in-order cache responses, discards responses that were in flight when a redirect arrived, and presents one instruction per cycle to decode with valid/ready.

## Interface
- XLEN, 64, PC/address width
- QDEPTH, 4, prefetch queue entries (power of two, ≥2); also the maximum number of requests in flight plus queued
- RESET_PC, 0, PC loaded on reset
- Clocking: reset RESET, synchronous, active-high; clock CLK.
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- REDIRECT_V  in  1  branch/jump redirect from WB
- REDIRECT_PC  in  XLEN  redirect target
- TRAP_V  in  1  trap redirect; has priority over REDIRECT_V
- MTVEC  in  XLEN  trap target
- IC_REQ_V  out  1  fetch request valid
- IC_REQ_PC  out  XLEN  fetch address
- IC_REQ_RDY  in  1  cache accepts request
- IC_RSP_V  in  1  response valid (in order, ≥1 cycle after request)
- IC_RSP_INSTR  in  32  instruction word
- IC_RSP_ERR  in  1  access fault on this response
- DE_V  out  1  queue head valid
- DE_READY  in  1  decode consumes head (low during hazard/mem stall)
- DE_IR  out  32  instruction
- DE_PC  out  XLEN  instruction PC
- DE_NPC  out  XLEN  DE_PC + 4
- DE_IAM  out  1  misaligned-fetch fault entry
- DE_IAF  out  1  access-fault entry

## Operation
- State machine: RUN, HALT.
  - In RUN, IC_REQ_V = 1 when (queue count + outstanding) < QDEPTH, drop_cnt = 0, and fetch_pc[1:0] = 0.
  - On handshake (IC_REQ_V & IC_REQ_RDY): outstanding +1, fetch_pc += 4 (mod 2^XLEN, wrap allowed).
- Misaligned PC in RUN (fetch_pc[1:0] ≠ 0):
  - No request is issued.
  - Once outstanding = 0 and a queue slot is free, push one entry: IAM = 1, IR = 0, PC = fetch_pc.
  - Go to HALT.
- Response with IC_RSP_ERR and drop_cnt = 0: push the entry with IAF = 1 and go to HALT. Responses still outstanding are counted into drop_cnt and discarded.
- HALT: no requests. Exit only via redirect.
- Responses:
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise push {IR, PC = rsp_pc, IAF} to the queue. rsp_pc is tracked by a register incremented by 4 per accepted response.
- Redirect (TRAP_V | REDIRECT_V), target = TRAP_V ? MTVEC : REDIRECT_PC:
  - Flush the queue.
  - fetch_pc = rsp_pc = target.
  - drop_cnt = outstanding minus a response arriving that same cycle. That same-cycle response is discarded.
  - State = RUN.
  - A request handshake in the same cycle is suppressed: IC_REQ_V is forced to 0 while a redirect is asserted.
- Decode: DE_* reflect the queue head. Pop on DE_V & DE_READY. A simultaneous push and pop is legal at full and at empty; count is unchanged at full.
- Queue is never overrun; guaranteed by the credit check. Outstanding never exceeds QDEPTH.

## Timing
- Reset values:
  - DE_V = 0, DE_IR = 0, DE_PC = 0, DE_NPC = 4, DE_IAM = 0, DE_IAF = 0, IC_REQ_V = 0.
  - fetch_pc = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0, state RUN.
  - First request is in the cycle after RESET deasserts.
- Redirect in cycle t: IC_REQ_V = 0 and DE_V = 0 in cycle t+1? No: queue is flushed at the t→t+1 edge, so DE_V = 0 in t+1. IC_REQ_PC = target in t+1, with IC_REQ_V high if drop_cnt = 0.
- Minimum latency, response to DE_V: 1 cycle (response registered into the queue; no bypass).
- RESET mid-operation: all state is cleared. Caller guarantees the cache discards its in-flight requests on RESET.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: adds outputs PERF_FETCHED (64-bit, instructions popped to decode), PERF_DROPPED (64-bit, responses discarded plus entries flushed), and PERF_STARVE (64-bit, cycles with DE_READY = 1 and DE_V = 0). All reset to 0 and wrap.
  - Undefined: none of these ports or counters exist; behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg:
  - typedef fetch_entry_t {ir[31:0], pc[XLEN-1:0], iam, iaf}
  - fetch state enum {FS_RUN, FS_HALT}
  - constant INSTR_BYTES = 4
- One sub-module: fetch_queue. Parametrised FIFO of fetch_entry_t, QDEPTH deep, with push/pop/flush, count, full and empty, and head output.

## Test plan
- Cache with 1-cycle RDY/RSP, DE_READY = 1 from reset, RESET_PC = 0x1000 → DE_PC = 0x1000, 0x1004, 0x1008 on consecutive cycles; DE_NPC = DE_PC + 4.
- DE_READY = 0 for 10 cycles, QDEPTH = 4 → exactly 4 requests issued, then IC_REQ_V stays 0. On release, 4 back-to-back pops, then streaming resumes.
- Cache with 3-cycle latency, 3 requests outstanding, REDIRECT_V with PC = 0x2000 → 3 responses discarded. Next DE_PC = 0x2000; PERF_DROPPED (macro on) increases by 3 + queue count.
- TRAP_V and REDIRECT_V in the same cycle, MTVEC = 0x8000, REDIRECT_PC = 0x3000 → next IC_REQ_PC = 0x8000.
- REDIRECT_PC = 0x2002 → no request; one entry with DE_IAM = 1, DE_PC = 0x2002; then HALT with IC_REQ_V = 0 until the next redirect.
- Response with IC_RSP_ERR at PC 0x100C → entry with DE_IAF = 1, DE_PC = 0x100C. Later outstanding responses are dropped and no further requests are made.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Entry PCs are stored at the widest supported address width; narrower builds truncate on output.
package fetch_pkg;

  localparam int XLEN_MAX    = 64;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0]         ir;
    logic [XLEN_MAX-1:0] pc;
    logic                iam;
    logic                iaf;
  } fetch_entry_t;

  typedef enum logic {
    FS_RUN,
    FS_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetch entries with push, pop and flush, presenting the head entry.
// Push while full is accepted only together with a pop, so count stays unchanged.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           pop_ok, push_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage is cleared on reset so the decode outputs read as zero before the first fill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: credit-limited sequential requests, in-order response queue, redirect drop.
// Optional FETCH_PERF_CNT_EN adds fetched / dropped / starve performance counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            REDIRECT_V,
  input  logic [XLEN-1:0] REDIRECT_PC,
  input  logic            TRAP_V,
  input  logic [XLEN-1:0] MTVEC,
  output logic            IC_REQ_V,
  output logic [XLEN-1:0] IC_REQ_PC,
  input  logic            IC_REQ_RDY,
  input  logic            IC_RSP_V,
  input  logic [31:0]     IC_RSP_INSTR,
  input  logic            IC_RSP_ERR,
  output logic            DE_V,
  input  logic            DE_READY,
  output logic [31:0]     DE_IR,
  output logic [XLEN-1:0] DE_PC,
  output logic [XLEN-1:0] DE_NPC,
  output logic            DE_IAM,
  output logic            DE_IAF
`ifdef FETCH_PERF_CNT_EN
 ,output logic [63:0]     PERF_FETCHED,
  output logic [63:0]     PERF_DROPPED,
  output logic [63:0]     PERF_STARVE
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            drop_cnt_q, drop_cnt_d;

  fetch_entry_t    q_entry, q_head;
  logic            q_push, q_flush, q_full, q_empty;
  cnt_t            q_count;

  logic            redirect, req_fire, de_pop, rsp_drop, pc_aligned, credit_ok;
  logic [XLEN-1:0] target;
  logic [CW:0]     in_use;

  assign redirect   = TRAP_V | REDIRECT_V;
  assign target     = TRAP_V ? MTVEC : REDIRECT_PC;
  assign pc_aligned = (fetch_pc_q[1:0] == 2'b00);
  assign in_use     = {1'b0, q_count} + {1'b0, outstanding_q};
  assign credit_ok  = (in_use < (CW+1)'(QDEPTH));

  // A redirect suppresses the request so the new target is the first address issued.
  assign IC_REQ_V  = ~RESET & ~redirect & (state_q == FS_RUN) & (drop_cnt_q == '0) & pc_aligned & credit_ok;
  assign IC_REQ_PC = fetch_pc_q;
  assign req_fire  = IC_REQ_V & IC_REQ_RDY;
  assign de_pop    = DE_V & DE_READY;

  assign DE_V   = ~q_empty;
  assign DE_IR  = q_head.ir;
  assign DE_PC  = q_head.pc[XLEN-1:0];
  assign DE_NPC = q_head.pc[XLEN-1:0] + XLEN'(INSTR_BYTES);
  assign DE_IAM = q_head.iam;
  assign DE_IAF = q_head.iaf;

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (q_push),
    .push_data (q_entry),
    .pop       (de_pop),
    .flush     (q_flush),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(IC_RSP_V);
    drop_cnt_d    = drop_cnt_q;
    q_push        = 1'b0;
    q_flush       = 1'b0;
    q_entry       = '0;
    rsp_drop      = 1'b0;
    if (redirect) begin
      // Every request still in flight after this cycle returns stale data and is discarded.
      q_flush    = 1'b1;
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_cnt_d = outstanding_d;
      state_d    = FS_RUN;
      rsp_drop   = IC_RSP_V;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      if (IC_RSP_V) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - cnt_t'(1);
          rsp_drop   = 1'b1;
        end else begin
          q_push     = 1'b1;
          q_entry.ir  = IC_RSP_INSTR;
          q_entry.pc  = XLEN_MAX'(rsp_pc_q);
          q_entry.iaf = IC_RSP_ERR;
          rsp_pc_d   = rsp_pc_q + XLEN'(INSTR_BYTES);
          if (IC_RSP_ERR) begin
            state_d    = FS_HALT;
            drop_cnt_d = outstanding_d;
          end
        end
      end else if ((state_q == FS_RUN) && !pc_aligned && (outstanding_q == '0) && !q_full) begin
        q_push     = 1'b1;
        q_entry.pc  = XLEN_MAX'(fetch_pc_q);
        q_entry.iam = 1'b1;
        state_d    = FS_HALT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= FS_RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched_q, perf_fetched_d;
  logic [63:0] perf_dropped_q, perf_dropped_d;
  logic [63:0] perf_starve_q, perf_starve_d;

  // Dropped counts both discarded responses and queue entries lost to a flush.
  always_comb begin
    perf_fetched_d = perf_fetched_q + 64'(de_pop);
    perf_dropped_d = perf_dropped_q + 64'(rsp_drop)
                     + (q_flush ? (64'(q_count) - 64'(de_pop)) : 64'd0);
    perf_starve_d  = perf_starve_q + 64'(DE_READY & ~DE_V);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_starve_q  <= perf_starve_d;
    end
  end

  assign PERF_FETCHED = perf_fetched_q;
  assign PERF_DROPPED = perf_dropped_q;
  assign PERF_STARVE  = perf_starve_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed testbench for fetch_prefetch with an in-order, fixed-latency instruction cache model.
module tb_fetch_prefetch;

  logic        CLK;
  logic        RESET;
  logic        REDIRECT_V;
  logic [63:0] REDIRECT_PC;
  logic        TRAP_V;
  logic [63:0] MTVEC;
  logic        IC_REQ_V;
  logic [63:0] IC_REQ_PC;
  logic        IC_REQ_RDY;
  logic        IC_RSP_V;
  logic [31:0] IC_RSP_INSTR;
  logic        IC_RSP_ERR;
  logic        DE_V;
  logic        DE_READY;
  logic [31:0] DE_IR;
  logic [63:0] DE_PC;
  logic [63:0] DE_NPC;
  logic        DE_IAM;
  logic        DE_IAF;

  int checks = 0;
  int errors = 0;

  fetch_prefetch #(.XLEN(64), .QDEPTH(4), .RESET_PC(64'h1000)) dut (
    .CLK(CLK), .RESET(RESET),
    .REDIRECT_V(REDIRECT_V), .REDIRECT_PC(REDIRECT_PC),
    .TRAP_V(TRAP_V), .MTVEC(MTVEC),
    .IC_REQ_V(IC_REQ_V), .IC_REQ_PC(IC_REQ_PC), .IC_REQ_RDY(IC_REQ_RDY),
    .IC_RSP_V(IC_RSP_V), .IC_RSP_INSTR(IC_RSP_INSTR), .IC_RSP_ERR(IC_RSP_ERR),
    .DE_V(DE_V), .DE_READY(DE_READY), .DE_IR(DE_IR), .DE_PC(DE_PC),
    .DE_NPC(DE_NPC), .DE_IAM(DE_IAM), .DE_IAF(DE_IAF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cache model: requests recorded at the clock edge, answered in order after 'lat' cycles.
  logic [63:0] pend_pc [$];
  longint      pend_cyc [$];
  longint      cyc = 0;
  int          lat = 1;
  int          req_cnt = 0;
  logic [63:0] err_pc = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [63:0] front_pc;

  always @(posedge CLK) begin
    if (RESET) begin
      pend_pc.delete();
      pend_cyc.delete();
      req_cnt = 0;
    end else begin
      if (IC_RSP_V) begin
        void'(pend_pc.pop_front());
        void'(pend_cyc.pop_front());
      end
      if (IC_REQ_V && IC_REQ_RDY) begin
        pend_pc.push_back(IC_REQ_PC);
        pend_cyc.push_back(cyc);
        req_cnt++;
      end
    end
    cyc++;
  end

  always @(negedge CLK) begin
    if (!RESET && pend_pc.size() > 0 && (cyc - pend_cyc[0]) >= longint'(lat)) begin
      front_pc     = pend_pc[0];
      IC_RSP_V     = 1'b1;
      IC_RSP_INSTR = front_pc[31:0] ^ 32'hDEAD_0000;
      IC_RSP_ERR   = (front_pc == err_pc);
    end else begin
      IC_RSP_V     = 1'b0;
      IC_RSP_INSTR = 32'h0;
      IC_RSP_ERR   = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Leaves RESET asserted at a falling edge; the caller releases it at that same edge.
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; REDIRECT_V = 1'b0; TRAP_V = 1'b0;
    REDIRECT_PC = '0; MTVEC = '0; IC_REQ_RDY = 1'b1; DE_READY = 1'b0;
    err_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (DE_V !== 1'b0) begin errors++; $display("[TB] FAIL reset_de_v: got %b expected 0", DE_V); end
    checks++; if (DE_IR !== 32'h0) begin errors++; $display("[TB] FAIL reset_de_ir: got %h expected 0", DE_IR); end
    checks++; if (DE_PC !== 64'h0) begin errors++; $display("[TB] FAIL reset_de_pc: got %h expected 0", DE_PC); end
    checks++; if (DE_NPC !== 64'h4) begin errors++; $display("[TB] FAIL reset_de_npc: got %h expected 4", DE_NPC); end
    checks++; if (DE_IAM !== 1'b0 || DE_IAF !== 1'b0) begin errors++; $display("[TB] FAIL reset_faults: got iam %b iaf %b expected 0 0", DE_IAM, DE_IAF); end
    checks++; if (IC_REQ_V !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_v: got %b expected 0", IC_REQ_V); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    do_reset();
    lat = 1; DE_READY = 1'b1; RESET = 1'b0;
    #1;
    checks++; if (IC_REQ_V !== 1'b1 || IC_REQ_PC !== 64'h1000) begin errors++; $display("[TB] FAIL stream_first_req: got v %b pc %h expected 1 1000", IC_REQ_V, IC_REQ_PC); end
    @(negedge CLK); #1;
    checks++; if (DE_V !== 1'b0) begin errors++; $display("[TB] FAIL stream_latency: got de_v %b expected 0", DE_V); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      exp_pc = 64'h1000 + 64'(4 * i);
      checks++; if (DE_V !== 1'b1 || DE_PC !== exp_pc) begin errors++; $display("[TB] FAIL stream_pc%0d: got v %b pc %h expected 1 %h", i, DE_V, DE_PC, exp_pc); end
      checks++; if (DE_NPC !== exp_pc + 64'h4) begin errors++; $display("[TB] FAIL stream_npc%0d: got %h expected %h", i, DE_NPC, exp_pc + 64'h4); end
      checks++; if (DE_IR !== (exp_pc[31:0] ^ 32'hDEAD_0000)) begin errors++; $display("[TB] FAIL stream_ir%0d: got %h expected %h", i, DE_IR, exp_pc[31:0] ^ 32'hDEAD_0000); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_pc;
    do_reset();
    lat = 1; DE_READY = 1'b0; RESET = 1'b0;
    repeat (10) @(negedge CLK);
    #1;
    checks++; if (req_cnt !== 4) begin errors++; $display("[TB] FAIL bp_req_count: got %0d expected 4", req_cnt); end
    checks++; if (IC_REQ_V !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_stalled: got %b expected 0", IC_REQ_V); end
    DE_READY = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_pc = 64'h1000 + 64'(4 * i);
      checks++; if (DE_V !== 1'b1 || DE_PC !== exp_pc) begin errors++; $display("[TB] FAIL bp_pop%0d: got v %b pc %h expected 1 %h", i, DE_V, DE_PC, exp_pc); end
      @(negedge CLK); #1;
    end
  endtask

  task automatic test_redirect_drop();
    bit seen = 0;
    do_reset();
    lat = 3; DE_READY = 1'b1; RESET = 1'b0;
    repeat (3) @(negedge CLK);
    REDIRECT_V = 1'b1; REDIRECT_PC = 64'h2000;
    #1;
    checks++; if (IC_REQ_V !== 1'b0) begin errors++; $display("[TB] FAIL rd_req_suppressed: got %b expected 0", IC_REQ_V); end
    @(negedge CLK);
    REDIRECT_V = 1'b0;
    #1;
    checks++; if (IC_REQ_PC !== 64'h2000 || IC_REQ_V !== 1'b0 || DE_V !== 1'b0) begin errors++; $display("[TB] FAIL rd_after: got pc %h v %b de_v %b expected 2000 0 0", IC_REQ_PC, IC_REQ_V, DE_V); end
    @(negedge CLK); #1;
    checks++; if (IC_REQ_V !== 1'b0) begin errors++; $display("[TB] FAIL rd_draining: got %b expected 0", IC_REQ_V); end
    @(negedge CLK); #1;
    checks++; if (IC_REQ_V !== 1'b1 || IC_REQ_PC !== 64'h2000) begin errors++; $display("[TB] FAIL rd_resume: got v %b pc %h expected 1 2000", IC_REQ_V, IC_REQ_PC); end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK); #1;
      if (DE_V) begin
        seen = 1;
        checks++; if (DE_PC !== 64'h2000 || DE_IR !== 32'hDEAD_2000) begin errors++; $display("[TB] FAIL rd_first_entry: got pc %h ir %h expected 2000 dead2000", DE_PC, DE_IR); end
      end
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL rd_timeout: got no entry expected entry within 20 cycles"); end
  endtask

  task automatic test_trap_priority();
    bit seen = 0;
    do_reset();
    lat = 1; DE_READY = 1'b0; RESET = 1'b0;
    repeat (8) @(negedge CLK);
    TRAP_V = 1'b1; MTVEC = 64'h8000; REDIRECT_V = 1'b1; REDIRECT_PC = 64'h3000;
    #1;
    checks++; if (IC_REQ_V !== 1'b0 || DE_V !== 1'b1) begin errors++; $display("[TB] FAIL trap_cycle: got req_v %b de_v %b expected 0 1", IC_REQ_V, DE_V); end
    @(negedge CLK);
    TRAP_V = 1'b0; REDIRECT_V = 1'b0;
    #1;
    checks++; if (DE_V !== 1'b0) begin errors++; $display("[TB] FAIL trap_flush: got de_v %b expected 0", DE_V); end
    checks++; if (IC_REQ_V !== 1'b1 || IC_REQ_PC !== 64'h8000) begin errors++; $display("[TB] FAIL trap_target: got v %b pc %h expected 1 8000", IC_REQ_V, IC_REQ_PC); end
    DE_READY = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK); #1;
      if (DE_V) begin
        seen = 1;
        checks++; if (DE_PC !== 64'h8000) begin errors++; $display("[TB] FAIL trap_entry: got pc %h expected 8000", DE_PC); end
      end
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL trap_timeout: got no entry expected entry within 10 cycles"); end
  endtask

  task automatic test_misaligned();
    bit seen = 0;
    int bad = 0;
    do_reset();
    lat = 1; DE_READY = 1'b1; RESET = 1'b0;
    repeat (5) @(negedge CLK);
    REDIRECT_V = 1'b1; REDIRECT_PC = 64'h2002;
    @(negedge CLK);
    REDIRECT_V = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (IC_REQ_V) bad++;
      if (DE_V) begin
        seen = 1;
        checks++; if (DE_IAM !== 1'b1 || DE_IAF !== 1'b0) begin errors++; $display("[TB] FAIL mis_flags: got iam %b iaf %b expected 1 0", DE_IAM, DE_IAF); end
        checks++; if (DE_PC !== 64'h2002 || DE_NPC !== 64'h2006 || DE_IR !== 32'h0) begin errors++; $display("[TB] FAIL mis_entry: got pc %h npc %h ir %h expected 2002 2006 0", DE_PC, DE_NPC, DE_IR); end
      end
      @(negedge CLK);
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL mis_timeout: got no entry expected IAM entry within 20 cycles"); end
    repeat (6) begin
      #1;
      if (IC_REQ_V || DE_V) bad++;
      @(negedge CLK);
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL mis_halt: got %0d active cycles expected 0", bad); end
    REDIRECT_V = 1'b1; REDIRECT_PC = 64'h4000;
    @(negedge CLK);
    REDIRECT_V = 1'b0;
    #1;
    checks++; if (IC_REQ_V !== 1'b1 || IC_REQ_PC !== 64'h4000) begin errors++; $display("[TB] FAIL mis_exit: got v %b pc %h expected 1 4000", IC_REQ_V, IC_REQ_PC); end
  endtask

  task automatic test_access_fault();
    logic [63:0] got_pc [4];
    logic        got_iaf [4];
    int n = 0;
    int bad = 0;
    do_reset();
    lat = 1; DE_READY = 1'b1; err_pc = 64'h100C; RESET = 1'b0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge CLK); #1;
      if (DE_V) begin
        got_pc[n]  = DE_PC;
        got_iaf[n] = DE_IAF;
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL af_entries: got %0d expected 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_pc[i] !== 64'h1000 + 64'(4 * i) || got_iaf[i] !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL af_entry%0d: got pc %h iaf %b expected %h %b", i, got_pc[i], got_iaf[i], 64'h1000 + 64'(4 * i), (i == 3));
      end
    end
    repeat (10) begin
      @(negedge CLK); #1;
      if (IC_REQ_V || DE_V) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL af_halt: got %0d active cycles expected 0", bad); end
    checks++; if (req_cnt !== 5) begin errors++; $display("[TB] FAIL af_req_count: got %0d expected 5", req_cnt); end
    err_pc = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  initial begin
    RESET = 1'b1; REDIRECT_V = 1'b0; TRAP_V = 1'b0; REDIRECT_PC = '0; MTVEC = '0;
    IC_REQ_RDY = 1'b1; DE_READY = 1'b0;
    IC_RSP_V = 1'b0; IC_RSP_INSTR = '0; IC_RSP_ERR = 1'b0;
    $display("[TB] starting fetch_prefetch bench");
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_trap_priority();
    test_misaligned();
    test_access_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
